axis_video_frame_arb: RTL and testbench
=======================================

# axis_video_frame_arb

Frame-aligned two-source AXI4-Stream video arbiter. It sits between two video producers (e.g. the random video generator and a capture path) and a single downstream video consumer. It forwards exactly one source at a time and switches sources only on whole-frame boundaries, so the consumer never sees a torn frame. The output passes through a one-stage register slice.

## Interface
- DW, 16: pixel data width.
- ACTIVE_VERT, 768: lines per frame. Must be ≥ 2.
- aclk  in  1  clock; all logic on the rising edge.
- aresetn  in  1  reset; **synchronous, active-low**.
- s0_tdata  in  DW; s0_tlast / s0_tuser / s0_tvalid  in  1; s0_tready  out  1: source 0 stream.
- s1_tdata  in  DW; s1_tlast / s1_tuser / s1_tvalid  in  1; s1_tready  out  1: source 1 stream.
- m_tdata  out  DW; m_tlast / m_tuser / m_tvalid  out  1; m_tready  in  1: output stream.
- sel_i  in  1: requested source, sampled every cycle.
- active_src  out  1: source currently owning the output.
- frame_done  out  1: one-cycle pulse when the last beat of a frame is accepted into the output slice.
- sof_err  out  1: one-cycle pulse on an unexpected tuser inside a frame.

## Operation
- State machine states: SYNC and PASS. Reset state: SYNC, with active_src = 0.
- **SYNC**
  - s[active_src]_tready = 1 whenever the output slice can load.
  - Beats without tuser are accepted and discarded.
  - The first accepted beat with tuser = 1 is loaded into the slice. Then line_cnt ← 0 and the state moves to PASS.
- **PASS**
  - Beats from s[active_src] are forwarded unchanged: tdata, tlast and tuser.
  - Each accepted beat with tlast = 1 increments line_cnt (16 bit).
  - When the tlast beat is accepted with line_cnt == ACTIVE_VERT-1:
    - frame_done pulses and line_cnt ← 0.
    - If sel_i ≠ active_src in that same cycle: active_src ← sel_i and the state moves to SYNC.
    - Otherwise the state stays in PASS.
- **Unexpected tuser:** a tuser = 1 beat in PASS with line_cnt ≠ 0, or not on the first beat after a tlast, pulses sof_err. It sets line_cnt ← 0 and is forwarded as a new frame start. active_src is unchanged.
- **Unselected source:** handling depends on the configuration (see Configuration).
- sel_i changes mid-frame have no effect until the frame boundary. Only sel_i at the boundary cycle matters.

## Timing
- Slice load condition: load = !m_tvalid || m_tready.
- s[active_src]_tready = load, in both SYNC and PASS. It is combinational from m_tvalid and m_tready.
- Forwarded beats: m_* is registered. An input beat appears on m_* on the cycle after acceptance, so latency = 1 cycle.
- Throughput: 1 beat/cycle with m_tready held high.
- While m_tvalid = 1 and m_tready = 0, m_tdata, m_tlast and m_tuser hold stable.
- A slice beat already loaded still drains normally after a switch. The first beat from the new source cannot precede it.
- frame_done and sof_err are registered, asserted the cycle after the causing acceptance, and high for exactly 1 cycle.
- Reset values:
  - m_tvalid = m_tlast = m_tuser = 0, m_tdata = 0.
  - active_src = 0, frame_done = sof_err = 0, line_cnt = 0, state = SYNC.
  - Reset asserted mid-frame discards the slice contents at the next clock edge. The block resyncs on source 0.

## Configuration
- FRAME_ARB_DRAIN_EN defined:
  - s[!active_src]_tready = 1; the unselected source's beats are consumed and dropped, so it free-runs.
  - On a switch, SYNC waits for that source's next tuser.
- Not defined: s[!active_src]_tready = 0, so the unselected source is back-pressured.

## Test plan
- Reset, then source 0 sends a 4-line frame (ACTIVE_VERT=4, 8 px/line) starting with junk beats before tuser → junk dropped, m_* carries 32 beats starting with tuser=1, frame_done pulses once, 1 cycle after the 32nd acceptance.
- Both sources stream continuously and sel_i goes 0→1 mid-frame 1 → frame 1 completes from s0. No s1 beat is forwarded until s1's next tuser. active_src = 1 from the cycle after the boundary.
- m_tready randomly deasserted at 50% during PASS → no beat lost or duplicated, m_* stable while stalled, beat order preserved.
- tuser injected on line 2, pixel 3 → sof_err pulses once, line_cnt restarts, and a full 4-line frame follows before frame_done.
- With FRAME_ARB_DRAIN_EN: s1_tready = 1 constantly while active_src = 0. Without it: s1_tready = 0 throughout.
- aresetn low for 1 cycle mid-frame on source 1:
  - next cycle m_tvalid = 0 and active_src = 0;
  - resumes on s0's next tuser.

Source files
------------

// File: rtl/axis_video_frame_arb.sv
// Frame-aligned two-source AXI4-Stream video arbiter with a one-stage output register slice.
// Optional build macro FRAME_ARB_DRAIN_EN: the unselected source free-runs and its beats are dropped.
module axis_video_frame_arb #(
   parameter int DW          = 16,
   parameter int ACTIVE_VERT = 768
) (
   input  logic          aclk,
   input  logic          aresetn,
   input  logic [DW-1:0] s0_tdata,
   input  logic          s0_tlast,
   input  logic          s0_tuser,
   input  logic          s0_tvalid,
   output logic          s0_tready,
   input  logic [DW-1:0] s1_tdata,
   input  logic          s1_tlast,
   input  logic          s1_tuser,
   input  logic          s1_tvalid,
   output logic          s1_tready,
   output logic [DW-1:0] m_tdata,
   output logic          m_tlast,
   output logic          m_tuser,
   output logic          m_tvalid,
   input  logic          m_tready,
   input  logic          sel_i,
   output logic          active_src,
   output logic          frame_done,
   output logic          sof_err
);

   typedef enum logic [0:0] {
      SYNC = 1'b0,
      PASS = 1'b1
   } state_t;

   localparam logic [15:0] LAST_LINE = 16'(ACTIVE_VERT - 1);

`ifdef FRAME_ARB_DRAIN_EN
   localparam logic DRAIN_RDY = 1'b1;
`else
   localparam logic DRAIN_RDY = 1'b0;
`endif

   state_t        state_r;
   logic [15:0]   line_cnt_r;
   logic          line_start_r;

   logic          load_s;
   logic          acc_s;
   logic          fwd_s;
   logic          unexp_s;
   logic          eof_s;
   logic          src_valid_s;
   logic          src_last_s;
   logic          src_user_s;
   logic [DW-1:0] src_data_s;

   // Source mux, ready generation and frame-position decode
   always_comb begin
      load_s      = !m_tvalid || m_tready;
      s0_tready   = active_src ? DRAIN_RDY : load_s;
      s1_tready   = active_src ? load_s : DRAIN_RDY;
      src_valid_s = active_src ? s1_tvalid : s0_tvalid;
      src_last_s  = active_src ? s1_tlast : s0_tlast;
      src_user_s  = active_src ? s1_tuser : s0_tuser;
      src_data_s  = active_src ? s1_tdata : s0_tdata;
      acc_s       = load_s && src_valid_s;
      // In SYNC only a frame start is allowed into the slice; everything else is dropped.
      fwd_s       = acc_s && ((state_r == PASS) || src_user_s);
      unexp_s     = src_user_s && ((line_cnt_r != 16'd0) || !line_start_r);
      eof_s       = src_last_s && (line_cnt_r == LAST_LINE);
   end

   // Arbitration FSM, line tracking, status pulses and output register slice
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_r      <= SYNC;
         line_cnt_r   <= 16'd0;
         line_start_r <= 1'b0;
         active_src   <= 1'b0;
         frame_done   <= 1'b0;
         sof_err      <= 1'b0;
         m_tvalid     <= 1'b0;
         m_tdata      <= {DW{1'b0}};
         m_tlast      <= 1'b0;
         m_tuser      <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         sof_err    <= 1'b0;
         if (load_s) begin
            m_tvalid <= fwd_s;
            if (fwd_s) begin
               m_tdata <= src_data_s;
               m_tlast <= src_last_s;
               m_tuser <= src_user_s;
            end
         end
         case (state_r)
            SYNC: begin
               if (fwd_s) begin
                  line_cnt_r   <= 16'd0;
                  line_start_r <= 1'b0;
                  state_r      <= PASS;
               end
            end
            PASS: begin
               if (acc_s) begin
                  if (unexp_s) begin
                     sof_err      <= 1'b1;
                     line_cnt_r   <= 16'd0;
                     line_start_r <= 1'b0;
                  end else if (src_last_s) begin
                     line_start_r <= 1'b1;
                     if (eof_s) begin
                        frame_done <= 1'b1;
                        line_cnt_r <= 16'd0;
                        // Only the request present on the boundary beat can move ownership.
                        if (sel_i != active_src) begin
                           active_src <= sel_i;
                           state_r    <= SYNC;
                        end
                     end else begin
                        line_cnt_r <= line_cnt_r + 16'd1;
                     end
                  end else begin
                     line_start_r <= 1'b0;
                  end
               end
            end
            default: begin
               state_r <= SYNC;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axis_video_frame_arb.sv
// Randomised self-checking bench for axis_video_frame_arb: two frame generators, a
// transaction-level reference model and directed literal checks of the headline behaviours.
module tb_axis_video_frame_arb;

   localparam int AV = 4;
   localparam int PX = 8;
`ifdef FRAME_ARB_DRAIN_EN
   localparam bit DRAIN = 1'b1;
`else
   localparam bit DRAIN = 1'b0;
`endif

   typedef struct packed {
      logic [15:0] data;
      logic        last;
      logic        user;
   } beat_t;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic [15:0] s0_tdata, s1_tdata, m_tdata;
   logic        s0_tlast, s0_tuser, s0_tvalid, s0_tready;
   logic        s1_tlast, s1_tuser, s1_tvalid, s1_tready;
   logic        m_tlast, m_tuser, m_tvalid, m_tready;
   logic        sel_i, active_src, frame_done, sof_err;

   axis_video_frame_arb #(.DW(16), .ACTIVE_VERT(AV)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .s0_tdata(s0_tdata), .s0_tlast(s0_tlast), .s0_tuser(s0_tuser),
      .s0_tvalid(s0_tvalid), .s0_tready(s0_tready),
      .s1_tdata(s1_tdata), .s1_tlast(s1_tlast), .s1_tuser(s1_tuser),
      .s1_tvalid(s1_tvalid), .s1_tready(s1_tready),
      .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tuser(m_tuser),
      .m_tvalid(m_tvalid), .m_tready(m_tready),
      .sel_i(sel_i), .active_src(active_src),
      .frame_done(frame_done), .sof_err(sof_err)
   );

   always #5 aclk = ~aclk;

   int checks = 0;
   int failures = 0;

   // generator state per source: line, pixel, sequence, valid, pending tuser injection
   int gl[2], gp[2], gs[2];
   bit gv[2], inj[2];
   int vprob, rprob;
   bit sel_v, rst_n_v;

   // reference model
   beat_t exp_q[$];
   bit    ma, efd, ese, syncing, line_start;
   int    lines;

   // directed observation state
   int mode;
   int outA, fdA, sofB, tlB;
   bit armB, doneB, seenS1, seenR, rst_chk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic beat_t beat_of(input int i);
      beat_t b;
      b.data     = 16'(gs[i]);
      b.data[15] = (i == 1);
      b.last     = (gp[i] == PX - 1);
      b.user     = (gl[i] == 0 && gp[i] == 0) || (inj[i] && gl[i] == 2 && gp[i] == 3);
      return b;
   endfunction

   task automatic gen_adv(input int i);
      if (inj[i] && gl[i] == 2 && gp[i] == 3) begin
         inj[i] = 1'b0;
         gl[i]  = 0;   // injected start restarts the source's own frame
      end
      gp[i]++;
      if (gp[i] == PX) begin
         gp[i] = 0;
         gl[i] = (gl[i] + 1) % AV;
      end
      gs[i]++;
      gv[i] = ($urandom_range(99) < vprob);
   endtask

   task automatic mreset();
      exp_q.delete();
      ma = 1'b0; efd = 1'b0; ese = 1'b0;
      syncing = 1'b1; line_start = 1'b0; lines = 0;
   endtask

   task automatic compare();
      if (exp_q.size() != 0) begin
         chk("m_tvalid", 32'(m_tvalid), 32'd1);
         chk("m_tdata", 32'(m_tdata), 32'(exp_q[0].data));
         chk("m_tlast", 32'(m_tlast), 32'(exp_q[0].last));
         chk("m_tuser", 32'(m_tuser), 32'(exp_q[0].user));
      end else begin
         chk("m_tvalid", 32'(m_tvalid), 32'd0);
      end
      chk("active_src", 32'(active_src), 32'(ma));
      chk("frame_done", 32'(frame_done), 32'(efd));
      chk("sof_err", 32'(sof_err), 32'(ese));
   endtask

   task automatic observe();
      if (rst_chk) begin
         chk("rst_mid_m_tvalid", 32'(m_tvalid), 32'd0);
         chk("rst_mid_active_src", 32'(active_src), 32'd0);
         rst_chk = 1'b0;
      end
      if (mode == 1) begin
         if (m_tvalid) begin
            outA++;
            if (outA == 1) chk("a_first_tuser", 32'(m_tuser), 32'd1);
         end
         if (frame_done) begin
            fdA++;
            if (fdA == 1) chk("a_beats_at_done", outA, 32'd32);
         end
      end else if (mode == 2) begin
         if (sof_err) begin
            sofB++;
            armB = 1'b1;
         end
         if (armB && m_tvalid && m_tlast) tlB++;
         if (armB && frame_done && !doneB) begin
            chk("sof_tlasts_before_done", tlB, 32'd4);
            doneB = 1'b1;
         end
      end else if (mode == 3) begin
         if (m_tvalid && m_tdata[15] && !seenS1) begin
            chk("s1_first_is_sof", 32'(m_tuser), 32'd1);
            seenS1 = 1'b1;
         end
      end else if (mode == 4) begin
         if (m_tvalid && !seenR) begin
            chk("post_reset_sof", 32'(m_tuser), 32'd1);
            chk("post_reset_src0", 32'(m_tdata[15]), 32'd0);
            seenR = 1'b1;
         end
      end
   endtask

   task automatic drive();
      beat_t b0, b1;
      for (int i = 0; i < 2; i++)
         if (!gv[i]) gv[i] = ($urandom_range(99) < vprob);
      b0 = beat_of(0);
      b1 = beat_of(1);
      aresetn   = rst_n_v;
      sel_i     = sel_v;
      m_tready  = ($urandom_range(99) < rprob);
      s0_tvalid = gv[0]; s0_tdata = b0.data; s0_tlast = b0.last; s0_tuser = b0.user;
      s1_tvalid = gv[1]; s1_tdata = b1.data; s1_tlast = b1.last; s1_tuser = b1.user;
   endtask

   task automatic model_step();
      bit    ld, e0, e1, a0, a1, acc;
      beat_t b;
      ld = (exp_q.size() == 0) || m_tready;
      e0 = (ma == 1'b0) ? ld : DRAIN;
      e1 = (ma == 1'b1) ? ld : DRAIN;
      chk("s0_tready", 32'(s0_tready), 32'(e0));
      chk("s1_tready", 32'(s1_tready), 32'(e1));
      a0 = gv[0] && e0;
      a1 = gv[1] && e1;
      if (!rst_n_v) begin
         mreset();
      end else begin
         efd = 1'b0;
         ese = 1'b0;
         if (m_tready && exp_q.size() != 0) void'(exp_q.pop_front());
         acc = ma ? a1 : a0;
         b   = beat_of(ma ? 1 : 0);
         if (acc) begin
            if (syncing) begin
               if (b.user) begin
                  exp_q.push_back(b);
                  syncing = 1'b0; lines = 0; line_start = 1'b0;
               end
            end else begin
               exp_q.push_back(b);
               if (b.user && (lines != 0 || !line_start)) begin
                  ese = 1'b1; lines = 0; line_start = 1'b0;
               end else if (b.last) begin
                  lines++;
                  line_start = 1'b1;
                  if (lines == AV) begin
                     efd = 1'b1;
                     lines = 0;
                     if (sel_i != ma) begin
                        ma = sel_i;
                        syncing = 1'b1;
                     end
                  end
               end else begin
                  line_start = 1'b0;
               end
            end
         end
      end
      if (a0) gen_adv(0);
      if (a1) gen_adv(1);
   endtask

   task automatic step();
      @(negedge aclk);
      compare();
      observe();
      drive();
      #1;
      model_step();
   endtask

   initial begin
      bit found;
      aresetn = 1'b0; m_tready = 1'b0; sel_i = 1'b0;
      s0_tvalid = 1'b0; s0_tdata = 16'd0; s0_tlast = 1'b0; s0_tuser = 1'b0;
      s1_tvalid = 1'b0; s1_tdata = 16'd0; s1_tlast = 1'b0; s1_tuser = 1'b0;
      mreset();
      gl[0] = 3; gp[0] = 4; gl[1] = 1; gp[1] = 5;   // s0 starts with 4 junk beats
      gs[0] = 0; gs[1] = 0; gv[0] = 1'b0; gv[1] = 1'b0; inj[0] = 1'b0; inj[1] = 1'b0;
      vprob = 100; rprob = 100; sel_v = 1'b0; rst_n_v = 1'b0;
      mode = 0; outA = 0; fdA = 0; sofB = 0; tlB = 0;
      armB = 1'b0; doneB = 1'b0; seenS1 = 1'b0; seenR = 1'b0; rst_chk = 1'b0;

      repeat (3) step();
      chk("reset_m_tvalid", 32'(m_tvalid), 32'd0);
      chk("reset_m_tdata", 32'(m_tdata), 32'd0);
      chk("reset_m_tlast", 32'(m_tlast), 32'd0);
      chk("reset_m_tuser", 32'(m_tuser), 32'd0);
      chk("reset_active_src", 32'(active_src), 32'd0);
      chk("reset_frame_done", 32'(frame_done), 32'd0);
      chk("reset_sof_err", 32'(sof_err), 32'd0);

      // first frame from s0 behind junk beats
      rst_n_v = 1'b1;
      mode = 1;
      for (int k = 0; k < 200 && fdA == 0; k++) step();
      repeat (3) step();
      chk("a_frame_done_once", fdA, 32'd1);

      // unexpected start of frame on line 2, pixel 3
      mode = 2;
      inj[0] = 1'b1;
      repeat (140) step();
      chk("sof_err_once", sofB, 32'd1);
      chk("sof_frame_done_seen", 32'(doneB), 32'd1);

      // request s1 mid-frame with both sources streaming
      mode = 3;
      sel_v = 1'b1;
      repeat (100) step();
      chk("switch_active_src", 32'(active_src), 32'd1);
      chk("switch_s1_seen", 32'(seenS1), 32'd1);

      // random traffic, back-pressure, selection changes and injected starts
      mode = 0;
      vprob = 70; rprob = 50;
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(49) == 0) sel_v = ~sel_v;
         if ($urandom_range(199) == 0) inj[$urandom_range(1)] = 1'b1;
         step();
      end

      // one-cycle reset in the middle of an s1 frame
      inj[0] = 1'b0; inj[1] = 1'b0;
      vprob = 100; rprob = 100; sel_v = 1'b1;
      found = 1'b0;
      for (int k = 0; k < 2000; k++) begin
         step();
         if (ma && !syncing && lines >= 1) begin
            found = 1'b1;
            break;
         end
      end
      chk("wait_midframe_s1", 32'(found), 32'd1);
      rst_n_v = 1'b0;
      step();
      rst_n_v = 1'b1;
      sel_v = 1'b0;
      rst_chk = 1'b1;
      mode = 4;
      repeat (150) step();
      chk("post_reset_seen", 32'(seenR), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
